fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Read-side consumer for the async FIFO. Drives the FIFO read port (rinc, rempty, read data) in the rclk domain and presents the words downstream as a valid/ready stream.
- Contains a 2-entry skid buffer, so it sustains one word per rclk while m_ready=1.
- rinc is never combinationally dependent on m_ready.
- Sits between the FIFO read port and any rclk-domain consumer.

Parameters:
DSIZE, 8, data width in bits; matches FIFO data width.
CNT_W, 16, width of the delivered-word counter (optional feature only).

Ports:
rclk  input  1  read-domain clock; all state on posedge rclk
rst  input  1  asynchronous, active-low reset
en  input  1  fetch enable; 0 stops new FIFO reads, buffered words still drain
rempty  input  1  FIFO empty flag (rclk domain)
rdata  input  DSIZE  FIFO read data, first-word-fall-through, valid while rempty=0
rinc  output  1  FIFO pop; word on rdata consumed at the rclk edge where rinc=1
m_data  output  DSIZE  stream data (oldest buffered word)
m_valid  output  1  m_data valid
m_ready  input  1  downstream accepts m_data at the rclk edge where m_valid&m_ready
word_cnt  output  CNT_W  words delivered (only with RD_STREAM_CNT_EN)

Behaviour:
- Reset (rst=0, async): buffer count=0, m_valid=0, m_data=0, word_cnt=0.
  - rinc is forced 0 combinationally while rst=0.
- Occupancy state is the buffer count: EMPTY(0), ONE(1), TWO(2). Two data registers: head and tail. m_data=head, m_valid=(count!=0).
- Pop decision: rinc = rst & en & ~rempty & (count!=TWO). It is a function of registered state and inputs only.
- push = rinc; pop = m_valid & m_ready, both sampled at the same edge.
- Transitions:
  - EMPTY: push -> ONE, head<=rdata.
  - ONE: push&pop -> ONE, head<=rdata. push only -> TWO, tail<=rdata. pop only -> EMPTY.
  - TWO: pop -> ONE, head<=tail. No push is possible in TWO.
- Latency: a word taken at edge N appears on m_data with m_valid=1 after edge N (1 rclk).
- Throughput: with en=1, rempty=0 and m_ready=1, count stays at ONE and one word transfers per rclk.
- Ordering: words leave in exact FIFO order. There is no drop and no duplication.
- Backpressure: m_ready=0 holds m_data/m_valid stable. At most 2 further words are popped, then rinc=0 until space frees.
- FIFO empty: rinc=0. m_valid falls only once the buffer drains.
- en falling mid-stream: no new rinc from that cycle on. Buffered words are still delivered.
- Reset mid-operation: buffered words are discarded. No rinc is issued during or after reset until the first edge with rst=1.

Optional Feature:
- Macro: RD_STREAM_CNT_EN.
- Defined: word_cnt increments by 1 on every edge with m_valid&m_ready, wraps at 2^CNT_W to 0, and resets to 0.
- Undefined: the word_cnt port and counter logic are absent. All other behaviour is identical.

Decomposition:
- Shared package fifo_pkg:
  - FIFO_DSIZE default (8).
  - Occupancy encoding constants OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_TWO=2'd2.
- Sub-module rd_skid_buf: the 2-entry head/tail buffer with push/pop/count.
- The top holds rinc generation and the optional counter.

Test Plan:
- Reset with rempty=0, en=1, rst=0 -> rinc=0, m_valid=0, word_cnt=0. After release, rinc=1 on the first edge.
- FIFO holds 1,2,3, m_ready=1 -> m_data 1,2,3 on consecutive edges, one rinc per edge, m_valid=0 afterwards.
- FIFO holds 4..8, m_ready=0 for 5 edges -> exactly 2 rincs, m_data=4 held. m_ready=1 then yields 4,5,6,7,8 in order.
- en=0 while buffer holds 2 words and rempty=0 -> rinc stays 0, both words delivered, then m_valid=0.
- rst pulsed low with count=TWO -> m_valid=0 immediately, buffered words lost, next delivered word is the FIFO head.
- RD_STREAM_CNT_EN with CNT_W=4: deliver 17 words -> word_cnt=1 (wrap).

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the async FIFO read-side stream: data width default and
// skid-buffer occupancy encoding.
package fifo_pkg;

    localparam int unsigned FIFO_DSIZE = 8;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    function automatic logic occ_has_space(input logic [1:0] occ);
        return occ != OCC_TWO;
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry head/tail skid buffer. Head is the oldest word; tail is only
// occupied when the buffer is full.
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = FIFO_DSIZE
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [DSIZE-1:0] i_data,
    output logic [DSIZE-1:0] o_head,
    output logic [1:0]       o_count
);

    logic [1:0]       r_count;
    logic [DSIZE-1:0] r_head;
    logic [DSIZE-1:0] r_tail;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= OCC_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_count)
                OCC_EMPTY: begin
                    if (i_push) begin
                        r_head  <= i_data;
                        r_count <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (i_push && i_pop) begin
                        r_head <= i_data;
                    end else if (i_push) begin
                        r_tail  <= i_data;
                        r_count <= OCC_TWO;
                    end else if (i_pop) begin
                        r_count <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // Full: the producer never pushes here, so only a pop matters.
                    if (i_pop) begin
                        r_head  <= r_tail;
                        r_count <= OCC_ONE;
                    end
                end
                default: r_count <= OCC_EMPTY;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-port consumer presenting words as a valid/ready stream through a
// 2-entry skid buffer. Optional delivered-word counter under RD_STREAM_CNT_EN.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = FIFO_DSIZE,
    parameter int unsigned CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rst,
    input  logic             en,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
`ifdef RD_STREAM_CNT_EN
    ,
    output logic [CNT_W-1:0] word_cnt
`endif
);

    logic [1:0] w_count;
    logic       w_pop;

    // Depends only on registered occupancy, never on m_ready.
    assign rinc    = rst & en & ~rempty & occ_has_space(w_count);
    assign m_valid = (w_count != OCC_EMPTY);
    assign w_pop   = m_valid & m_ready;

    rd_skid_buf #(
        .DSIZE (DSIZE)
    ) u_skid (
        .i_clk   (rclk),
        .i_rst_n (rst),
        .i_push  (rinc),
        .i_pop   (w_pop),
        .i_data  (rdata),
        .o_head  (m_data),
        .o_count (w_count)
    );

`ifdef RD_STREAM_CNT_EN
    logic [CNT_W-1:0] r_word_cnt;

    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            r_word_cnt <= '0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + 1'b1;
        end
    end

    assign word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: constant vector tables for the directed sequences plus
// a queue-based model for every cycle. Build with RD_STREAM_CNT_EN to check word_cnt.
module tb_fifo_rd_stream;

    localparam int unsigned DSIZE = 8;
    localparam int unsigned CNT_W = 16;

    logic             rclk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             rempty = 1'b1;
    logic [DSIZE-1:0] rdata = '0;
    logic             rinc;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
`ifdef RD_STREAM_CNT_EN
    logic [CNT_W-1:0] word_cnt;
`endif

    always #5 rclk = ~rclk;

    fifo_rd_stream #(
        .DSIZE (DSIZE),
        .CNT_W (CNT_W)
    ) dut (
        .rclk    (rclk),
        .rst     (rst),
        .en      (en),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
`ifdef RD_STREAM_CNT_EN
        ,
        .word_cnt (word_cnt)
`endif
    );

    typedef struct {
        logic             en;
        logic             rdy;
        logic             rinc;
        logic             valid;
        logic [DSIZE-1:0] data;
    } vec_t;

    vec_t             vecs[$];
    logic [DSIZE-1:0] src[$];   // words sitting in the FIFO, front = rdata
    logic [DSIZE-1:0] mq[$];    // words held by the consumer, front = m_data
    int unsigned      n_deliv;
    int               total = 0;
    int               bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic r);
        en      = e;
        m_ready = r;
        rempty  = (src.size() == 0);
        if (src.size() != 0) rdata = src[0];
        else rdata = 8'hEE;
        #1;
    endtask

    // Consumer pulls when enabled, FIFO has data, and it holds fewer than 2 words.
    function automatic logic model_rinc();
        return rst && en && (src.size() != 0) && (mq.size() < 2);
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".rinc"}, 32'(rinc), 32'(model_rinc()));
        chk({tag, ".valid"}, 32'(m_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk({tag, ".data"}, 32'(m_data), 32'(mq[0]));
`ifdef RD_STREAM_CNT_EN
        chk({tag, ".cnt"}, 32'(word_cnt), n_deliv % (1 << CNT_W));
`endif
    endtask

    task automatic advance();
        logic take;
        logic give;
        take = model_rinc();
        give = rst && (mq.size() != 0) && m_ready;
        @(posedge rclk);
        if (give) begin
            void'(mq.pop_front());
            n_deliv++;
        end
        if (take) mq.push_back(src.pop_front());
        @(negedge rclk);
    endtask

    task automatic step(input logic e, input logic r, input string tag);
        drive(e, r);
        check_model(tag);
        advance();
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].rdy);
            chk($sformatf("%s[%0d].rinc", tag, i), 32'(rinc), 32'(vecs[i].rinc));
            chk($sformatf("%s[%0d].valid", tag, i), 32'(m_valid), 32'(vecs[i].valid));
            if (vecs[i].valid) begin
                chk($sformatf("%s[%0d].data", tag, i), 32'(m_data), 32'(vecs[i].data));
            end
            check_model(tag);
            advance();
        end
        vecs.delete();
    endtask

    task automatic do_reset_assert();
        rst = 1'b0;
        mq.delete();
        n_deliv = 0;
    endtask

    initial begin
        n_deliv = 0;

        // Reset held with data available and enable high.
        src = '{8'd1, 8'd2, 8'd3};
        do_reset_assert();
        drive(1'b1, 1'b1);
        chk("reset.rinc", 32'(rinc), 32'd0);
        chk("reset.valid", 32'(m_valid), 32'd0);
        chk("reset.data", 32'(m_data), 32'd0);
`ifdef RD_STREAM_CNT_EN
        chk("reset.cnt", 32'(word_cnt), 32'd0);
`endif
        advance();
        rst = 1'b1;

        // Streaming 1,2,3 at full rate.
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'd1});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'd2});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 8'd3});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        run_vecs("stream");

        // Backpressure: 5 cycles of m_ready=0 then drain 4..8.
        for (int w = 4; w <= 8; w++) src.push_back(8'(w));
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'd0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 8'd4});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'd4});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'd4});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'd4});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 8'd4});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'd5});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'd6});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'd7});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 8'd8});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        run_vecs("bp");

        // en drops with a full buffer and more data waiting.
        src = '{8'd10, 8'd11, 8'd12, 8'd13};
        step(1'b1, 1'b0, "en0.fill");
        step(1'b1, 1'b0, "en0.fill");
        step(1'b0, 1'b0, "en0.hold");
        step(1'b0, 1'b1, "en0.drain");
        step(1'b0, 1'b1, "en0.drain");
        drive(1'b0, 1'b1);
        chk("en0.rinc_off", 32'(rinc), 32'd0);
        chk("en0.empty_valid", 32'(m_valid), 32'd0);
        check_model("en0.end");
        advance();

        // Reset with the buffer full: 12,13 are lost, 20 is next.
        src.push_back(8'd20);
        src.push_back(8'd21);
        step(1'b1, 1'b0, "rst.fill");
        step(1'b1, 1'b0, "rst.fill");
        do_reset_assert();
        drive(1'b1, 1'b1);
        chk("rst.mid_valid", 32'(m_valid), 32'd0);
        chk("rst.mid_rinc", 32'(rinc), 32'd0);
        chk("rst.mid_data", 32'(m_data), 32'd0);
        advance();
        rst = 1'b1;
        step(1'b1, 1'b1, "rst.after");
        drive(1'b1, 1'b1);
        chk("rst.first_word", 32'(m_data), 32'd20);
        check_model("rst.next");
        advance();
        step(1'b1, 1'b1, "rst.after");
        step(1'b1, 1'b1, "rst.after");

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) != 0 && src.size() < 6) src.push_back(8'($urandom));
            step(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), "rand");
        end
        for (int c = 0; c < 10; c++) step(1'b1, 1'b1, "flush");
        drive(1'b1, 1'b1);
        chk("flush.valid", 32'(m_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
